// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter for a single-port memory.
// Ties go to the requester not granted last. A stalled memory is aborted after MAX_WAIT cycles.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ireq_i,
    input  logic [ADDR_W-1:0] iaddr_i,
    output logic              iack_o,
    output logic [DATA_W-1:0] irdata_o,
    input  logic              dreq_i,
    input  logic              dwe_i,
    input  logic [ADDR_W-1:0] daddr_i,
    input  logic [DATA_W-1:0] dwdata_i,
    output logic              dack_o,
    output logic [DATA_W-1:0] drdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic              err_o
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] ISERV = 2'b01;
    localparam logic [1:0] DSERV = 2'b10;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    // Abort pattern, truncated or zero-extended to the data width.
    function automatic logic [DATA_W-1:0] abort_word();
        logic [DATA_W+31:0] ext_v;
        ext_v = {{DATA_W{1'b0}}, 32'hDEADBEEF};
        return ext_v[DATA_W-1:0];
    endfunction

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              last_grant_r;
    logic              last_grant_nxt_s;
    logic [7:0]        wait_cnt_r;
    logic [7:0]        wait_cnt_nxt_s;
    logic [7:0]        wait_inc_s;
    logic              timeout_s;
    logic              i_elig_s;
    logic              d_elig_s;
    logic              grant_i_s;
    logic              grant_d_s;
    logic              mem_req_nxt_s;
    logic              mem_we_nxt_s;
    logic [ADDR_W-1:0] mem_addr_nxt_s;
    logic [DATA_W-1:0] mem_wdata_nxt_s;
    logic              iack_nxt_s;
    logic              dack_nxt_s;
    logic [DATA_W-1:0] irdata_nxt_s;
    logic [DATA_W-1:0] drdata_nxt_s;
    logic              err_nxt_s;

    // A requester is blocked for grant during its own ack cycle.
    always_comb begin
        i_elig_s   = ireq_i & ~iack_o;
        d_elig_s   = dreq_i & ~dack_o;
        grant_d_s  = d_elig_s & (~i_elig_s | (last_grant_r == GNT_I));
        grant_i_s  = i_elig_s & ~grant_d_s;
        wait_inc_s = wait_cnt_r + 8'd1;
        timeout_s  = (wait_inc_s == MAX_WAIT_C);
    end

    // Pipeline freeze while either requester is still waiting for its ack.
    assign stall_o = (ireq_i & ~iack_o) | (dreq_i & ~dack_o);

    // Next-state and next-output computation.
    always_comb begin
        state_nxt_s      = state_r;
        last_grant_nxt_s = last_grant_r;
        wait_cnt_nxt_s   = wait_cnt_r;
        mem_req_nxt_s    = mem_req_o;
        mem_we_nxt_s     = mem_we_o;
        mem_addr_nxt_s   = mem_addr_o;
        mem_wdata_nxt_s  = mem_wdata_o;
        iack_nxt_s       = 1'b0;
        dack_nxt_s       = 1'b0;
        irdata_nxt_s     = irdata_o;
        drdata_nxt_s     = drdata_o;
        err_nxt_s        = err_o;
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    state_nxt_s      = DSERV;
                    last_grant_nxt_s = GNT_D;
                    wait_cnt_nxt_s   = 8'd0;
                    mem_req_nxt_s    = 1'b1;
                    mem_we_nxt_s     = dwe_i;
                    mem_addr_nxt_s   = daddr_i;
                    mem_wdata_nxt_s  = dwdata_i;
                end else if (grant_i_s) begin
                    state_nxt_s      = ISERV;
                    last_grant_nxt_s = GNT_I;
                    wait_cnt_nxt_s   = 8'd0;
                    mem_req_nxt_s    = 1'b1;
                    mem_we_nxt_s     = 1'b0;
                    mem_addr_nxt_s   = iaddr_i;
                    mem_wdata_nxt_s  = {DATA_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISERV: begin
                if (mem_ack_i) begin
                    irdata_nxt_s  = mem_rdata_i;
                    iack_nxt_s    = 1'b1;
                    mem_req_nxt_s = 1'b0;
                    state_nxt_s   = IDLE;
                end else if (timeout_s) begin
                    irdata_nxt_s   = abort_word();
                    iack_nxt_s     = 1'b1;
                    err_nxt_s      = 1'b1;
                    mem_req_nxt_s  = 1'b0;
                    wait_cnt_nxt_s = wait_inc_s;
                    state_nxt_s    = IDLE;
                end else begin
                    wait_cnt_nxt_s = wait_inc_s;
                end
            end
            DSERV: begin
                if (mem_ack_i) begin
                    // A store acknowledges without touching the load-data register.
                    if (!mem_we_o) begin
                        drdata_nxt_s = mem_rdata_i;
                    end else begin
                        drdata_nxt_s = drdata_o;
                    end
                    dack_nxt_s    = 1'b1;
                    mem_req_nxt_s = 1'b0;
                    mem_we_nxt_s  = 1'b0;
                    state_nxt_s   = IDLE;
                end else if (timeout_s) begin
                    drdata_nxt_s   = abort_word();
                    dack_nxt_s     = 1'b1;
                    err_nxt_s      = 1'b1;
                    mem_req_nxt_s  = 1'b0;
                    mem_we_nxt_s   = 1'b0;
                    wait_cnt_nxt_s = wait_inc_s;
                    state_nxt_s    = IDLE;
                end else begin
                    wait_cnt_nxt_s = wait_inc_s;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                mem_req_nxt_s = 1'b0;
                mem_we_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r      <= IDLE;
            last_grant_r <= GNT_I;
            wait_cnt_r   <= 8'd0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= {ADDR_W{1'b0}};
            mem_wdata_o  <= {DATA_W{1'b0}};
            iack_o       <= 1'b0;
            dack_o       <= 1'b0;
            irdata_o     <= {DATA_W{1'b0}};
            drdata_o     <= {DATA_W{1'b0}};
            err_o        <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            wait_cnt_r   <= wait_cnt_nxt_s;
            mem_req_o    <= mem_req_nxt_s;
            mem_we_o     <= mem_we_nxt_s;
            mem_addr_o   <= mem_addr_nxt_s;
            mem_wdata_o  <= mem_wdata_nxt_s;
            iack_o       <= iack_nxt_s;
            dack_o       <= dack_nxt_s;
            irdata_o     <= irdata_nxt_s;
            drdata_o     <= drdata_nxt_s;
            err_o        <= err_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected completions are queued when requests
// are driven and checked in order when iack_o / dack_o pulse.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          ireq_i;
    logic [AW-1:0] iaddr_i;
    logic          iack_o;
    logic [DW-1:0] irdata_o;
    logic          dreq_i;
    logic          dwe_i;
    logic [AW-1:0] daddr_i;
    logic [DW-1:0] dwdata_i;
    logic          dack_o;
    logic [DW-1:0] drdata_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i;
    logic [DW-1:0] mem_rdata_i;
    logic          stall_o;
    logic          err_o;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(15)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ireq_i(ireq_i), .iaddr_i(iaddr_i), .iack_o(iack_o), .irdata_o(irdata_o),
        .dreq_i(dreq_i), .dwe_i(dwe_i), .daddr_i(daddr_i), .dwdata_i(dwdata_i),
        .dack_o(dack_o), .drdata_o(drdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] iq[$];
    logic [31:0] dq[$];
    bit          oq[$];
    logic [31:0] i_model;
    logic [31:0] d_model;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h8C22_0004;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic push_i(input logic [31:0] v);
        iq.push_back(v);
        oq.push_back(1'b0);
        i_model = v;
    endtask

    task automatic push_d(input logic [31:0] v);
        dq.push_back(v);
        oq.push_back(1'b1);
        d_model = v;
    endtask

    bit          mem_auto;
    int          mem_lat;
    int          mem_cnt;
    int          req_cycles;
    logic [31:0] snap_addr;
    logic        snap_we;
    logic [31:0] snap_wdata;

    // Memory model: acks mem_lat cycles after mem_req_o rises.
    initial begin
        mem_cnt = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (mem_auto) begin
                if (mem_req_o && mem_cnt == mem_lat) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = mem_val(mem_addr_o);
                    mem_cnt     = 0;
                end else begin
                    mem_ack_i = 1'b0;
                    if (mem_req_o) mem_cnt++;
                    else mem_cnt = 0;
                end
            end
        end
    end

    // Completion monitor: pops the scoreboard on every ack pulse.
    initial begin
        req_cycles = 0;
        forever begin
            @(negedge clk_i);
            if (mem_req_o) begin
                req_cycles++;
                snap_addr  = mem_addr_o;
                snap_we    = mem_we_o;
                snap_wdata = mem_wdata_o;
            end
            if (iack_o) begin
                if (iq.size() == 0 || oq.size() == 0) check("spurious_iack", iack_o, 1'b0);
                else begin
                    check("order_i", oq.pop_front(), 1'b0);
                    check("irdata", irdata_o, iq.pop_front());
                end
            end
            if (dack_o) begin
                if (dq.size() == 0 || oq.size() == 0) check("spurious_dack", dack_o, 1'b0);
                else begin
                    check("order_d", oq.pop_front(), 1'b1);
                    check("drdata", drdata_o, dq.pop_front());
                end
            end
        end
    end

    task automatic i_req(input logic [31:0] addr, output int lat);
        bit done;
        done    = 1'b0;
        lat     = 0;
        ireq_i  = 1'b1;
        iaddr_i = addr;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk_i);
            lat++;
            if (iack_o) done = 1'b1;
        end
        check("i_done", done, 1'b1);
        ireq_i = 1'b0;
    endtask

    task automatic d_req(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                         output int lat);
        bit done;
        done     = 1'b0;
        lat      = 0;
        dreq_i   = 1'b1;
        dwe_i    = we;
        daddr_i  = addr;
        dwdata_i = wd;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk_i);
            lat++;
            if (dack_o) done = 1'b1;
        end
        check("d_done", done, 1'b1);
        dreq_i = 1'b0;
        dwe_i  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, mem_req_o, 1'b0);
        check({tag, "_mem_we"}, mem_we_o, 1'b0);
        check({tag, "_mem_addr"}, mem_addr_o, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
        check({tag, "_iack"}, iack_o, 1'b0);
        check({tag, "_dack"}, dack_o, 1'b0);
        check({tag, "_irdata"}, irdata_o, 32'h0);
        check({tag, "_drdata"}, drdata_o, 32'h0);
        check({tag, "_err"}, err_o, 1'b0);
    endtask

    int lat_i;
    int lat_d;

    initial begin
        rst_i = 1'b0; ireq_i = 1'b0; iaddr_i = '0; dreq_i = 1'b0; dwe_i = 1'b0;
        daddr_i = '0; dwdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
        mem_auto = 1'b1; mem_lat = 0; i_model = '0; d_model = '0;
        #12;
        check_all_zero("reset");
        check("reset_stall", stall_o, 1'b0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        // First tie after reset: D wins, then I.
        push_d(mem_val(32'h100));
        push_i(mem_val(32'h80));
        fork
            d_req(32'h100, 1'b0, 32'h0, lat_d);
            i_req(32'h80, lat_i);
        join
        check("tie1_lat_d", lat_d, 3);
        check("tie1_lat_i", lat_i, 5);

        // Single fetch at minimum latency.
        @(posedge clk_i); #1;
        req_cycles = 0;
        push_i(32'h8C22_0004);
        i_req(32'h40, lat_i);
        check("fetch_lat", lat_i, 3);
        check("fetch_req_cycles", req_cycles, 1);
        check("fetch_addr", snap_addr, 32'h40);
        check("fetch_we", snap_we, 1'b0);
        check("fetch_irdata", irdata_o, 32'h8C22_0004);
        #1;
        check("fetch_stall", stall_o, 1'b0);

        // Store with one wait cycle; load-data register must not change.
        mem_lat = 1;
        @(posedge clk_i); #1;
        req_cycles = 0;
        push_d(d_model);
        d_req(32'h200, 1'b1, 32'h1234_5678, lat_d);
        check("store_lat", lat_d, 4);
        check("store_req_cycles", req_cycles, 2);
        check("store_addr", snap_addr, 32'h200);
        check("store_we", snap_we, 1'b1);
        check("store_wdata", snap_wdata, 32'h1234_5678);
        check("store_drdata", drdata_o, mem_val(32'h100));

        // Second tie: D was granted last, so I wins.
        mem_lat = 0;
        @(posedge clk_i); #1;
        push_i(mem_val(32'h84));
        push_d(mem_val(32'h104));
        fork
            i_req(32'h84, lat_i);
            d_req(32'h104, 1'b0, 32'h0, lat_d);
        join
        check("tie2_lat_i", lat_i, 3);
        check("tie2_lat_d", lat_d, 5);

        // Timeout on a fetch: memory never answers.
        mem_auto = 1'b0; mem_ack_i = 1'b0;
        @(posedge clk_i); #1;
        req_cycles = 0;
        push_i(32'hDEAD_BEEF);
        i_req(32'h300, lat_i);
        check("to_lat", lat_i, 17);
        check("to_req_cycles", req_cycles, 15);
        check("to_err", err_o, 1'b1);
        check("to_mem_req", mem_req_o, 1'b0);

        // Stray ack in IDLE must be ignored.
        @(posedge clk_i); #1;
        req_cycles = 0;
        mem_rdata_i = 32'hFFFF_FFFF;
        mem_ack_i = 1'b1;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("stray_req_cycles", req_cycles, 0);
        check("stray_irdata", irdata_o, 32'hDEAD_BEEF);
        check("stray_drdata", drdata_o, mem_val(32'h104));
        check("stray_acks", {iack_o, dack_o}, 2'b00);
        mem_cnt = 0; mem_auto = 1'b1;
        @(posedge clk_i); #1;
        push_i(mem_val(32'h44));
        i_req(32'h44, lat_i);
        check("stray_next_lat", lat_i, 3);
        check("err_sticky", err_o, 1'b1);

        // Reset in the middle of a data transaction.
        mem_auto = 1'b0; mem_ack_i = 1'b0;
        @(posedge clk_i); #1;
        dreq_i = 1'b1; daddr_i = 32'h400; dwe_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        check("mid_mem_req", mem_req_o, 1'b1);
        check("mid_mem_addr", mem_addr_o, 32'h400);
        rst_i = 1'b0;
        #1;
        check_all_zero("async_rst");
        dreq_i = 1'b0; i_model = '0; d_model = '0;
        repeat (3) @(negedge clk_i);
        check("rst_no_dack", dack_o, 1'b0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        mem_cnt = 0; mem_auto = 1'b1;
        push_i(mem_val(32'h48));
        i_req(32'h48, lat_i);
        check("post_rst_lat", lat_i, 3);
        check("post_rst_err", err_o, 1'b0);

        repeat (3) @(negedge clk_i);
        check("sb_empty", iq.size() + dq.size() + oq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
